// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared widths, command encodings and request types for the
// cache-to-DRAM request bridge.
package mem_bridge_pkg;
   localparam int ADDR_W_DEF = 27;
   localparam int LINE_W_DEF = 128;
   localparam logic CMD_READ = 1'b1;
   localparam logic CMD_WRITE = 1'b0;
   typedef struct packed {
      logic rw;
      logic [ADDR_W_DEF-1:0] addr;
      logic [LINE_W_DEF-1:0] data;
   } port_req_t;
   typedef enum logic {IDLE, HOLD} req_state_t;
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order FIFO of requester indices for reads awaiting DRAM data.
// Callers never push when full nor pop when empty.
module tag_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= din;
   assign dout = mem_q[rd_q];
   assign full = cnt_q == CW'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter feeding one held request at a time to the
// DRAM master FIFO, routing in-order read data back to the requesting port.
module mem_req_arbiter
   import mem_bridge_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 sys_clk,
   input  logic                                 rst,
   input  logic [N_PORTS-1:0]                   port_req_valid,
   input  logic [N_PORTS-1:0]                   port_req_rw,
   input  logic [N_PORTS*ADDR_W-1:0]            port_req_addr,
   input  logic [N_PORTS*LINE_W-1:0]            port_req_data,
   output logic [N_PORTS-1:0]                   port_req_ready,
   output logic [N_PORTS-1:0]                   port_rsp_valid,
   output logic [LINE_W-1:0]                    port_rsp_data,
   output logic                                 fifo_req_en,
   output logic                                 fifo_req_cmd,
   output logic [ADDR_W-1:0]                    fifo_req_addr,
   output logic [LINE_W-1:0]                    fifo_req_data,
   input  logic                                 fifo_req_rdy,
   input  logic                                 fifo_rsp_en,
   input  logic [LINE_W-1:0]                    fifo_rsp_data,
   output logic                                 fifo_rsp_rdy,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 err_unexpected_rsp
);
   localparam int TAG_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   req_state_t state_q, state_d;
   logic rw_q, rw_d, err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
   logic [N_PORTS-1:0] ready_q, ready_d, rsp_valid_q, rsp_valid_d;
   logic [TAG_W-1:0] rr_q, rr_d, win, tag_head;
   logic grant, xfer, push, pop, tag_full, tag_empty;
   // A port whose ready is pulsing is excluded so one valid is never granted twice.
   always_comb begin
      int idx;
      idx = 0;
      win = '0;
      grant = 1'b0;
      xfer = state_q == HOLD && fifo_req_rdy;
      for (int k = 0; k < N_PORTS; k++) begin
         idx = (int'(rr_q) + k) % N_PORTS;
         if (!grant && port_req_valid[idx] && !ready_q[idx] && (port_req_rw[idx] || !tag_full)) begin
            grant = 1'b1;
            win = TAG_W'(idx);
         end
      end
      grant = grant && (state_q == IDLE || xfer);
      push = grant && !port_req_rw[win];
      pop = fifo_rsp_en && !tag_empty;
      state_d = grant ? HOLD : xfer ? IDLE : state_q;
      ready_d = grant ? N_PORTS'(1) << win : '0;
      rr_d = grant ? TAG_W'((int'(win) + 1) % N_PORTS) : rr_q;
      rw_d = grant ? port_req_rw[win] : rw_q;
      addr_d = grant ? port_req_addr[win*ADDR_W +: ADDR_W] : addr_q;
      data_d = grant ? port_req_data[win*LINE_W +: LINE_W] : data_q;
      rsp_valid_d = pop ? N_PORTS'(1) << tag_head : '0;
      rsp_data_d = pop ? fifo_rsp_data : rsp_data_q;
      err_d = err_q || (fifo_rsp_en && tag_empty);
   end
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         rw_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         ready_q <= '0;
         rr_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rw_q <= rw_d;
         addr_q <= addr_d;
         data_q <= data_d;
         ready_q <= ready_d;
         rr_q <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q <= rsp_data_d;
         err_q <= err_d;
      end
   tag_fifo #(.DEPTH(MAX_OUTSTANDING), .W(TAG_W)) u_tags (
      .clk(sys_clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(win),
      .dout(tag_head),
      .full(tag_full),
      .empty(tag_empty),
      .count(outstanding)
   );
   assign fifo_req_en = state_q == HOLD;
   assign fifo_req_cmd = state_q == HOLD ? (rw_q ? CMD_WRITE : CMD_READ) : 1'b0;
   assign fifo_req_addr = addr_q;
   assign fifo_req_data = data_q;
   assign fifo_rsp_rdy = 1'b1;
   assign port_req_ready = ready_q;
   assign port_rsp_valid = rsp_valid_q;
   assign port_rsp_data = rsp_data_q;
   assign err_unexpected_rsp = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: random requesters against a transaction-level model of
// round-robin grants, tag order and in-order read returns.
module tb_mem_req_arbiter;
   import mem_bridge_pkg::*;
   localparam int NP = 3;
   localparam int AW = ADDR_W_DEF;
   localparam int LW = LINE_W_DEF;
   localparam int MO = 4;
   localparam int CW = $clog2(MO + 1);
   typedef struct {
      int port;
      logic [LW-1:0] data;
   } rsp_t;
   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   port_req_t req [NP];
   logic [NP-1:0] vld = '0;
   logic [NP-1:0] p_rw;
   logic [NP*AW-1:0] p_addr;
   logic [NP*LW-1:0] p_data;
   logic fifo_req_rdy = 1'b0, fifo_rsp_en = 1'b0;
   logic [LW-1:0] fifo_rsp_data = '0;
   logic [NP-1:0] ready, rsp_valid;
   logic [LW-1:0] rsp_data, req_data;
   logic req_en, req_cmd, rsp_rdy, err;
   logic [AW-1:0] req_addr;
   logic [CW-1:0] outstanding;
   port_req_t exp_req_q[$];
   rsp_t exp_rsp_q[$];
   int tagq[$];
   int m_rr, m_pred;
   bit m_hold, m_hold_nx, m_err;
   int compared = 0, mismatched = 0;
   port_req_t mon_req;
   rsp_t mon_rsp;
   logic [NP-1:0] mon_vec;

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign p_rw[g] = req[g].rw;
      assign p_addr[g*AW +: AW] = req[g].addr;
      assign p_data[g*LW +: LW] = req[g].data;
   end

   mem_req_arbiter #(.N_PORTS(NP), .MAX_OUTSTANDING(MO)) dut (
      .sys_clk(sys_clk),
      .rst(rst),
      .port_req_valid(vld),
      .port_req_rw(p_rw),
      .port_req_addr(p_addr),
      .port_req_data(p_data),
      .port_req_ready(ready),
      .port_rsp_valid(rsp_valid),
      .port_rsp_data(rsp_data),
      .fifo_req_en(req_en),
      .fifo_req_cmd(req_cmd),
      .fifo_req_addr(req_addr),
      .fifo_req_data(req_data),
      .fifo_req_rdy(fifo_req_rdy),
      .fifo_rsp_en(fifo_rsp_en),
      .fifo_rsp_data(fifo_rsp_data),
      .fifo_rsp_rdy(rsp_rdy),
      .outstanding(outstanding),
      .err_unexpected_rsp(err)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant seen on the last edge: record the transfer and tag it implies, retire the requester.
   task automatic check_edge();
      logic [NP-1:0] er;
      er = '0;
      if (m_pred >= 0) er[m_pred] = 1'b1;
      chk("port_req_ready", LW'(ready), LW'(er));
      if (m_pred >= 0) begin
         exp_req_q.push_back(req[m_pred]);
         if (!req[m_pred].rw) tagq.push_back(m_pred);
         vld[m_pred] = 1'b0;
      end
      m_hold = m_hold_nx;
      chk("fifo_req_en", LW'(req_en), LW'(m_hold));
      chk("outstanding", LW'(outstanding), LW'(tagq.size()));
      chk("err_unexpected_rsp", LW'(err), LW'(m_err));
   endtask

   task automatic drive(input int p_req, input int p_rdy, input int p_rsp, input bit force_err);
      int occ, nxt, idx;
      bit can;
      for (int i = 0; i < NP; i++)
         if (!vld[i] && $urandom_range(99) < p_req) begin
            vld[i] = 1'b1;
            req[i].rw = 1'($urandom_range(1));
            req[i].addr = AW'({$urandom, $urandom});
            req[i].data = {$urandom, $urandom, $urandom, $urandom};
         end
      fifo_req_rdy = $urandom_range(99) < p_rdy;
      occ = tagq.size();
      can = !m_hold || fifo_req_rdy;
      nxt = -1;
      for (int k = 0; k < NP; k++) begin
         idx = (m_rr + k) % NP;
         if (can && nxt < 0 && vld[idx] && idx != m_pred && (req[idx].rw || occ < MO)) nxt = idx;
      end
      if (nxt >= 0) begin
         m_rr = (nxt + 1) % NP;
         m_hold_nx = 1'b1;
      end else m_hold_nx = m_hold && !fifo_req_rdy;
      fifo_rsp_en = 1'b0;
      if ((tagq.size() > 0 && $urandom_range(99) < p_rsp) || force_err) begin
         fifo_rsp_en = 1'b1;
         fifo_rsp_data = {$urandom, $urandom, $urandom, $urandom};
         if (tagq.size() > 0) exp_rsp_q.push_back('{tagq.pop_front(), fifo_rsp_data});
         else m_err = 1'b1;
      end
      m_pred = nxt;
   endtask

   task automatic step(input int p_req, input int p_rdy, input int p_rsp, input bit force_err);
      @(posedge sys_clk);
      #1;
      check_edge();
      drive(p_req, p_rdy, p_rsp, force_err);
   endtask

   task automatic do_reset();
      @(posedge sys_clk);
      #1;
      rst = 1'b1;
      fifo_rsp_en = 1'b0;
      fifo_req_rdy = 1'b0;
      exp_req_q.delete();
      exp_rsp_q.delete();
      tagq.delete();
      m_rr = 0;
      m_pred = -1;
      m_hold = 1'b0;
      m_hold_nx = 1'b0;
      m_err = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      chk("rst_fifo_req_en", LW'(req_en), '0);
      chk("rst_fifo_req_cmd", LW'(req_cmd), '0);
      chk("rst_fifo_req_addr", LW'(req_addr), '0);
      chk("rst_port_req_ready", LW'(ready), '0);
      chk("rst_port_rsp_valid", LW'(rsp_valid), '0);
      chk("rst_port_rsp_data", rsp_data, '0);
      chk("rst_outstanding", LW'(outstanding), '0);
      chk("rst_err", LW'(err), '0);
      chk("rst_fifo_rsp_rdy", LW'(rsp_rdy), LW'(1));
      rst = 1'b0;
   endtask

   initial forever begin
      @(negedge sys_clk);
      if (!rst) begin
         if (req_en && fifo_req_rdy) begin
            if (exp_req_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL fifo_transfer: got unexpected transfer addr %0h expected none", req_addr);
            end else begin
               mon_req = exp_req_q.pop_front();
               chk("fifo_req_cmd", LW'(req_cmd), LW'(!mon_req.rw));
               chk("fifo_req_addr", LW'(req_addr), LW'(mon_req.addr));
               chk("fifo_req_data", req_data, mon_req.data);
            end
         end
         if (rsp_valid != '0) begin
            if (exp_rsp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL port_rsp_valid: got %0h expected 0", rsp_valid);
            end else begin
               mon_rsp = exp_rsp_q.pop_front();
               mon_vec = '0;
               mon_vec[mon_rsp.port] = 1'b1;
               chk("port_rsp_valid", LW'(rsp_valid), LW'(mon_vec));
               chk("port_rsp_data", rsp_data, mon_rsp.data);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < NP; i++) req[i] = '0;
      do_reset();
      req[0] = '{1'b0, AW'('h0000100), {4{32'h1234_5678}}};
      vld[0] = 1'b1;
      drive(0, 100, 0, 0);
      step(0, 100, 0, 0);
      chk("first_read_en", LW'(req_en), LW'(1));
      chk("first_read_cmd", LW'(req_cmd), LW'(CMD_READ));
      chk("first_read_addr", LW'(req_addr), LW'('h0000100));
      chk("first_read_ready", LW'(ready), LW'(1));
      repeat (40) step(90, 100, 0, 0);
      chk("saturated_outstanding", LW'(outstanding), LW'(MO));
      repeat (60) step(90, 30, 0, 0);
      repeat (250) step(70, 60, 40, 0);
      repeat (40) step(0, 100, 100, 0);
      chk("drain_req_queue", LW'(exp_req_q.size()), '0);
      chk("drain_rsp_queue", LW'(exp_rsp_q.size()), '0);
      chk("drain_outstanding", LW'(outstanding), '0);
      step(0, 100, 0, 1);
      repeat (4) step(0, 100, 0, 0);
      chk("err_sticky", LW'(err), LW'(1));
      repeat (6) step(90, 0, 0, 0);
      do_reset();
      drive(80, 100, 50, 0);
      repeat (150) step(80, 70, 50, 0);
      repeat (40) step(0, 100, 100, 0);
      chk("final_req_queue", LW'(exp_req_q.size()), '0);
      chk("final_rsp_queue", LW'(exp_rsp_q.size()), '0);
      chk("final_outstanding", LW'(outstanding), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
